matmul_sequencer: RTL and testbench

- Parametrised main controller for the matrix-multiplication datapath.
- Sequences a full M×N result matrix. Each element goes through load, K-step multiply-accumulate, and store.
- Drives one-hot phase gates plus row/col/k indices to the operand fetch, MAC array and result writer.
- Generalises the fixed three-state prepare/process/complete controller to configurable dimensions, with stall, abort and restart.

---
 rtl/matmul_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_matmul_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_sequencer.sv
// matmul_sequencer: main controller for the matrix-multiplication datapath.
// Walks an M x N result matrix; each element is a LOAD cycle, K MAC steps
// and a STORE handshake. Supports stall (operand_ready / result_ack), abort
// and restart directly from DONE.
//
// Ports:
//   clock, reset_n            rising-edge clock, async active-low reset
//   start                     begin a new multiply (accepted in IDLE/DONE)
//   abort                     return to IDLE from any state, indices cleared
//   operand_ready             operands for (row,col,k) available
//   result_ack                result writer accepted the current element
//   status                    encoded state (IDLE=000 LOAD=001 MAC=010 STORE=011 DONE=111)
//   g_load, g_mac, g_store    one-hot phase gates
//   row, col, k               current indices
//   done                      matrix complete
//   stall_cycles, busy_cycles 32-bit saturating counters (MATMUL_SEQ_PERF_EN only)
//
// Optional feature macro: MATMUL_SEQ_PERF_EN adds the performance counters.
module matmul_sequencer #(
  parameter int unsigned M  = 4,
  parameter int unsigned N  = 4,
  parameter int unsigned K  = 4,
  parameter int unsigned RW = $clog2(M > 1 ? M : 2),
  parameter int unsigned CW = $clog2(N > 1 ? N : 2),
  parameter int unsigned KW = $clog2(K > 1 ? K : 2)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          start,
  input  logic          abort,
  input  logic          operand_ready,
  input  logic          result_ack,
  output logic [2:0]    status,
  output logic          g_load,
  output logic          g_mac,
  output logic          g_store,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic [KW-1:0] k,
  output logic          done
`ifdef MATMUL_SEQ_PERF_EN
  ,
  output logic [31:0]   stall_cycles,
  output logic [31:0]   busy_cycles
`endif
);

  localparam logic [2:0] ST_IDLE  = 3'b000;
  localparam logic [2:0] ST_LOAD  = 3'b001;
  localparam logic [2:0] ST_MAC   = 3'b010;
  localparam logic [2:0] ST_STORE = 3'b011;
  localparam logic [2:0] ST_DONE  = 3'b111;

  localparam logic [RW-1:0] RowMax = RW'(M - 1);
  localparam logic [CW-1:0] ColMax = CW'(N - 1);
  localparam logic [KW-1:0] KMax   = KW'(K - 1);

  logic [2:0]    r_state, w_state_d;
  logic [RW-1:0] r_row, w_row_d;
  logic [CW-1:0] r_col, w_col_d;
  logic [KW-1:0] r_k, w_k_d;
  logic          w_start_ok;

  assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  always_comb begin
    w_state_d = r_state;
    w_row_d   = r_row;
    w_col_d   = r_col;
    w_k_d     = r_k;
    if (abort) begin
      w_state_d = ST_IDLE;
      w_row_d   = '0;
      w_col_d   = '0;
      w_k_d     = '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            w_state_d = ST_LOAD;
            w_row_d   = '0;
            w_col_d   = '0;
            w_k_d     = '0;
          end
        end
        ST_LOAD: begin
          if (operand_ready) begin
            w_state_d = ST_MAC;
            w_k_d     = '0;
          end
        end
        ST_MAC: begin
          // Without operand_ready the step is stalled; k and state hold.
          if (operand_ready) begin
            if (r_k == KMax) begin
              w_state_d = ST_STORE;
            end else begin
              w_k_d = r_k + KW'(1);
            end
          end
        end
        ST_STORE: begin
          if (result_ack) begin
            if (r_col != ColMax) begin
              w_col_d   = r_col + CW'(1);
              w_k_d     = '0;
              w_state_d = ST_LOAD;
            end else if (r_row != RowMax) begin
              w_col_d   = '0;
              w_row_d   = r_row + RW'(1);
              w_k_d     = '0;
              w_state_d = ST_LOAD;
            end else begin
              // Last element: indices keep their final values in DONE.
              w_state_d = ST_DONE;
            end
          end
        end
        default: begin
          w_state_d = ST_IDLE;
          w_row_d   = '0;
          w_col_d   = '0;
          w_k_d     = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_k     <= '0;
    end else begin
      r_state <= w_state_d;
      r_row   <= w_row_d;
      r_col   <= w_col_d;
      r_k     <= w_k_d;
    end
  end

  // Outputs decode only registered state.
  assign status  = r_state;
  assign g_load  = (r_state == ST_LOAD);
  assign g_mac   = (r_state == ST_MAC);
  assign g_store = (r_state == ST_STORE);
  assign done    = (r_state == ST_DONE);
  assign row     = r_row;
  assign col     = r_col;
  assign k       = r_k;

`ifdef MATMUL_SEQ_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_busy_cycles;
  logic        w_busy;
  logic        w_stall;

  assign w_busy  = g_load || g_mac || g_store;
  assign w_stall = ((g_load || g_mac) && !operand_ready) || (g_store && !result_ack);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cycles <= '0;
      r_busy_cycles  <= '0;
    end else if (abort || w_start_ok) begin
      r_stall_cycles <= '0;
      r_busy_cycles  <= '0;
    end else begin
      if (w_busy && (r_busy_cycles != '1)) begin
        r_busy_cycles <= r_busy_cycles + 32'd1;
      end
      if (w_stall && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign busy_cycles  = r_busy_cycles;
`else
  logic w_unused;
  assign w_unused = w_start_ok;
`endif

endmodule

// File: tb/tb_matmul_sequencer.sv
module tb_matmul_sequencer;

  logic       clock;
  logic       reset_n;
  logic       start, abort, operand_ready, result_ack;
  logic [2:0] status;
  logic       g_load, g_mac, g_store, done;
  logic [0:0] row;
  logic [0:0] col;
  logic [1:0] k;
`ifdef MATMUL_SEQ_PERF_EN
  logic [31:0] stall_cycles, busy_cycles;
`endif

  logic       start_b;
  logic [2:0] status_b;
  logic       g_load_b, g_mac_b, g_store_b, done_b;
  logic [0:0] row_b, col_b, k_b;
`ifdef MATMUL_SEQ_PERF_EN
  logic [31:0] stall_cycles_b, busy_cycles_b;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] sb_q[$];

  matmul_sequencer #(.M(2), .N(2), .K(3)) u_dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .start         (start),
    .abort         (abort),
    .operand_ready (operand_ready),
    .result_ack    (result_ack),
    .status        (status),
    .g_load        (g_load),
    .g_mac         (g_mac),
    .g_store       (g_store),
    .row           (row),
    .col           (col),
    .k             (k),
    .done          (done)
`ifdef MATMUL_SEQ_PERF_EN
    ,
    .stall_cycles  (stall_cycles),
    .busy_cycles   (busy_cycles)
`endif
  );

  matmul_sequencer #(.M(1), .N(1), .K(1)) u_dut_b (
    .clock         (clock),
    .reset_n       (reset_n),
    .start         (start_b),
    .abort         (1'b0),
    .operand_ready (1'b1),
    .result_ack    (1'b1),
    .status        (status_b),
    .g_load        (g_load_b),
    .g_mac         (g_mac_b),
    .g_store       (g_store_b),
    .row           (row_b),
    .col           (col_b),
    .k             (k_b),
    .done          (done_b)
`ifdef MATMUL_SEQ_PERF_EN
    ,
    .stall_cycles  (stall_cycles_b),
    .busy_cycles   (busy_cycles_b)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one full matrix on the 2x2x3 instance from a negedge in IDLE or DONE.
  // or_stall: cycles operand_ready is dropped in MAC at (0,0) k=1.
  // ack_stall: cycles result_ack is withheld in STORE at (0,1).
  task automatic run_matrix(input string tag, input int exp_edges, input int or_stall,
                            input int ack_stall);
    int edges, macs, st01, stall_left, ack_left;
    logic or_v, ack_v, prev_stall;
    logic [7:0] exp_el;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) sb_q.push_back({4'(r), 4'(c)});
    operand_ready = 1'b1;
    result_ack    = 1'b1;
    start         = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    chk({tag, "_load_status"}, 32'(status), 32'h1);
    chk({tag, "_load_idx"}, {26'd0, row, col, k, 2'b00}, 32'd0);
    chk({tag, "_load_done"}, 32'(done), 32'd0);
`ifdef MATMUL_SEQ_PERF_EN
    chk({tag, "_perf_clr"}, busy_cycles | stall_cycles, 32'd0);
`endif
    edges = 0; macs = 0; st01 = 0;
    stall_left = or_stall; ack_left = ack_stall; prev_stall = 1'b0;
    while (!done && edges < 200) begin
      or_v = 1'b1;
      if (g_mac && row == 1'b0 && col == 1'b0 && k == 2'd1 && stall_left > 0) begin
        or_v = 1'b0;
        stall_left--;
      end
      ack_v = 1'b1;
      if (g_store && row == 1'b0 && col == 1'b1) begin
        st01++;
        if (ack_left > 0) begin
          ack_v = 1'b0;
          ack_left--;
        end
      end
      if (g_mac) macs++;
      if (prev_stall) begin
        chk({tag, "_stall_k"}, 32'(k), 32'd1);
        chk({tag, "_stall_gmac"}, 32'(g_mac), 32'd1);
      end
      prev_stall = !or_v;
      if (g_store && ack_v) begin
        if (sb_q.size() == 0) begin
          chk({tag, "_sb_underflow"}, 32'(sb_q.size()), 32'd1);
        end else begin
          exp_el = sb_q.pop_front();
          chk({tag, "_elem"}, {24'd0, 4'(row), 4'(col)}, {24'd0, exp_el});
        end
      end
      operand_ready = or_v;
      result_ack    = ack_v;
      @(posedge clock);
      edges++;
      @(negedge clock);
    end
    operand_ready = 1'b1;
    result_ack    = 1'b1;
    chk({tag, "_done_edges"}, 32'(edges), 32'(exp_edges));
    chk({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
    chk({tag, "_mac_cycles"}, 32'(macs), 32'(12 + or_stall));
    chk({tag, "_store01_cycles"}, 32'(st01), 32'(1 + ack_stall));
    chk({tag, "_final_status"}, 32'(status), 32'h7);
    chk({tag, "_final_idx"}, {27'd0, row, col, 1'b0, k}, {27'd0, 1'b1, 1'b1, 1'b0, 2'd2});
`ifdef MATMUL_SEQ_PERF_EN
    chk({tag, "_busy"}, busy_cycles, 32'(exp_edges));
    chk({tag, "_stall"}, stall_cycles, 32'(or_stall + ack_stall));
`endif
    sb_q.delete();
  endtask

  initial begin
    int guard;
    reset_n = 1'b0;
    start = 1'b0; abort = 1'b0; operand_ready = 1'b0; result_ack = 1'b0;
    start_b = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_status", 32'(status), 32'd0);
    chk("rst_idx", {29'd0, row, col, k} , 32'd0);
    chk("rst_gates", {28'd0, g_load, g_mac, g_store, done}, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("idle_hold", 32'(status), 32'd0);

    run_matrix("basic", 20, 0, 0);
    run_matrix("restart_opstall", 22, 2, 0);
    run_matrix("ackstall", 25, 0, 5);

    // Abort in MAC at element (1,0) with operand_ready high.
    operand_ready = 1'b1; result_ack = 1'b1;
    start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    guard = 0;
    while (!(g_mac && row == 1'b1 && col == 1'b0) && guard < 100) begin
      @(posedge clock);
      @(negedge clock);
      guard++;
    end
    chk("abort_reach", 32'(g_mac && row == 1'b1 && col == 1'b0), 32'd1);
    abort = 1'b1;
    @(posedge clock);
    @(negedge clock);
    abort = 1'b0;
    chk("abort_status", 32'(status), 32'd0);
    chk("abort_idx", {29'd0, row, col, k}, 32'd0);
    chk("abort_gates", {28'd0, g_load, g_mac, g_store, done}, 32'd0);
`ifdef MATMUL_SEQ_PERF_EN
    chk("abort_perf", busy_cycles | stall_cycles, 32'd0);
`endif
    run_matrix("after_abort", 20, 0, 0);

    // Asynchronous reset mid-MAC at element (0,1), k=1.
    start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    guard = 0;
    while (!(g_mac && col == 1'b1 && k == 2'd1) && guard < 100) begin
      @(posedge clock);
      @(negedge clock);
      guard++;
    end
    chk("arst_reach", 32'(g_mac && col == 1'b1 && k == 2'd1), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_status", 32'(status), 32'd0);
    chk("arst_idx", {29'd0, row, col, k}, 32'd0);
    chk("arst_gates", {28'd0, g_load, g_mac, g_store, done}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // 1x1x1 instance: LOAD, MAC, STORE, DONE.
    start_b = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start_b = 1'b0;
    chk("b_load", {28'd0, g_load_b, g_mac_b, g_store_b, done_b}, 32'b1000);
    @(posedge clock);
    @(negedge clock);
    chk("b_mac", {28'd0, g_load_b, g_mac_b, g_store_b, done_b}, 32'b0100);
    @(posedge clock);
    @(negedge clock);
    chk("b_store", {28'd0, g_load_b, g_mac_b, g_store_b, done_b}, 32'b0010);
    @(posedge clock);
    @(negedge clock);
    chk("b_done", {29'd0, status_b}, 32'h7);
    chk("b_idx", {29'd0, row_b, col_b, k_b}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
